// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the two-requester memory arbiter.
`timescale 1ns/1ps
package mem_arb_pkg;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int SIZE_W  = 4;
  localparam int TIMER_W = 16;

  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, RESP = 2'd2} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_CPU = 2'd1, OWN_AUX = 2'd2} owner_t;

  // A request must be exactly one of read or write.
  function automatic logic proto_err(input logic rd, input logic wr);
    return rd == wr;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester, memory-port and debug signals of the arbiter; slave = arbiter side.
`timescale 1ns/1ps
interface mem_arbiter_if;
  import mem_arb_pkg::*;

  logic              cpu_valid;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_read;
  logic              cpu_write;
  logic [SIZE_W-1:0] cpu_size;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ready;
  logic              cpu_err;

  logic              aux_valid;
  logic [ADDR_W-1:0] aux_addr;
  logic [DATA_W-1:0] aux_wdata;
  logic              aux_read;
  logic              aux_write;
  logic [SIZE_W-1:0] aux_size;
  logic [DATA_W-1:0] aux_rdata;
  logic              aux_ready;
  logic              aux_err;

  logic              mem_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [SIZE_W-1:0] mem_size;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;

  modport slave (
    input  cpu_valid, cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size,
    output cpu_rdata, cpu_ready, cpu_err,
    input  aux_valid, aux_addr, aux_wdata, aux_read, aux_write, aux_size,
    output aux_rdata, aux_ready, aux_err,
    output mem_valid, mem_addr, mem_wdata, mem_read, mem_write, mem_size,
    input  mem_ready, mem_rdata,
    output owner
  );

  modport master (
    output cpu_valid, cpu_addr, cpu_wdata, cpu_read, cpu_write, cpu_size,
    input  cpu_rdata, cpu_ready, cpu_err,
    output aux_valid, aux_addr, aux_wdata, aux_read, aux_write, aux_size,
    input  aux_rdata, aux_ready, aux_err,
    input  mem_valid, mem_addr, mem_wdata, mem_read, mem_write, mem_size,
    output mem_ready, mem_rdata,
    input  owner
  );

endinterface

// File: rtl/mem_arb_timer.sv
// Bounded-wait counter: flags expiry when the count reaches TIMEOUT-1.
`timescale 1ns/1ps
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)     count_d = '0;
    else if (en_i) count_d = count_q + TIMER_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign expired_o = (count_q == LIMIT);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU and an auxiliary requester.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter bit CPU_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  arb_state_t        state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              last_aux_q, last_aux_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [SIZE_W-1:0] size_q, size_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] aux_rdata_q, aux_rdata_d;

  logic grant_cpu, grant_aux, grant, sel_read, sel_write, sel_bad, expired;

  // Under contention the requester that did not win last time gets the port.
  assign grant_cpu = bus.cpu_valid && (!bus.aux_valid || last_aux_q);
  assign grant_aux = bus.aux_valid && !grant_cpu;
  assign grant     = (state_q == IDLE) && (grant_cpu || grant_aux);
  assign sel_read  = grant_cpu ? bus.cpu_read  : bus.aux_read;
  assign sel_write = grant_cpu ? bus.cpu_write : bus.aux_write;
  assign sel_bad   = proto_err(sel_read, sel_write);

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (grant),
    .en_i      (state_q == XFER),
    .expired_o (expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Errors (protocol or timeout) also pass through RESP so the pulse lands outside IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = sel_bad ? RESP : XFER;
      XFER:    if (bus.mem_ready || expired) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_aux_d  = last_aux_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    read_d      = read_q;
    write_d     = write_q;
    size_d      = size_q;
    cpu_rdata_d = cpu_rdata_q;
    aux_rdata_d = aux_rdata_q;
    if (grant) begin
      owner_d    = grant_cpu ? OWN_CPU : OWN_AUX;
      last_aux_d = grant_aux;
      err_d      = sel_bad;
      addr_d     = grant_cpu ? bus.cpu_addr  : bus.aux_addr;
      wdata_d    = grant_cpu ? bus.cpu_wdata : bus.aux_wdata;
      size_d     = grant_cpu ? bus.cpu_size  : bus.aux_size;
      read_d     = sel_read;
      write_d    = sel_write;
    end else if (state_q == XFER) begin
      if (bus.mem_ready) begin
        err_d = 1'b0;
        if (owner_q == OWN_AUX) aux_rdata_d = bus.mem_rdata;
        else                    cpu_rdata_d = bus.mem_rdata;
      end else if (expired) begin
        err_d = 1'b1;
      end
    end else if (state_q == RESP) begin
      owner_d = OWN_NONE;
      err_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q     <= OWN_NONE;
      last_aux_q  <= CPU_FIRST;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= '0;
      cpu_rdata_q <= '0;
      aux_rdata_q <= '0;
    end else begin
      owner_q     <= owner_d;
      last_aux_q  <= last_aux_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      read_q      <= read_d;
      write_q     <= write_d;
      size_q      <= size_d;
      cpu_rdata_q <= cpu_rdata_d;
      aux_rdata_q <= aux_rdata_d;
    end
  end

  always_comb begin
    bus.mem_valid = (state_q == XFER);
    bus.mem_read  = (state_q == XFER) && read_q;
    bus.mem_write = (state_q == XFER) && write_q;
    bus.mem_addr  = addr_q;
    bus.mem_wdata = wdata_q;
    bus.mem_size  = size_q;
    bus.cpu_ready = (state_q == RESP) && (owner_q == OWN_CPU) && !err_q;
    bus.cpu_err   = (state_q == RESP) && (owner_q == OWN_CPU) &&  err_q;
    bus.aux_ready = (state_q == RESP) && (owner_q == OWN_AUX) && !err_q;
    bus.aux_err   = (state_q == RESP) && (owner_q == OWN_AUX) &&  err_q;
    bus.cpu_rdata = cpu_rdata_q;
    bus.aux_rdata = aux_rdata_q;
    bus.owner     = owner_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: vector table of single transfers plus contention, timeout and reset sequences.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(8), .CPU_FIRST(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        aux;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
    logic [3:0]  size;
    int          waits;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rdy(input logic aux);
    return aux ? 32'(bus.aux_ready) : 32'(bus.cpu_ready);
  endfunction

  function automatic logic [31:0] err(input logic aux);
    return aux ? 32'(bus.aux_err) : 32'(bus.cpu_err);
  endfunction

  function automatic logic [31:0] rdat(input logic aux);
    return aux ? bus.aux_rdata : bus.cpu_rdata;
  endfunction

  task automatic clear_req();
    bus.cpu_valid = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.cpu_read = 0; bus.cpu_write = 0; bus.cpu_size = '0;
    bus.aux_valid = 0; bus.aux_addr = '0; bus.aux_wdata = '0;
    bus.aux_read = 0; bus.aux_write = 0; bus.aux_size = '0;
  endtask

  task automatic set_req(input vec_t v);
    if (v.aux) begin
      bus.aux_valid = 1; bus.aux_addr = v.addr; bus.aux_wdata = v.wdata;
      bus.aux_read = v.rd; bus.aux_write = v.wr; bus.aux_size = v.size;
    end else begin
      bus.cpu_valid = 1; bus.cpu_addr = v.addr; bus.cpu_wdata = v.wdata;
      bus.cpu_read = v.rd; bus.cpu_write = v.wr; bus.cpu_size = v.size;
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    set_req(v);
    bus.mem_ready = 0;
    tick();
    if (v.rd == v.wr) begin
      chk({tag, " proto_err"}, err(v.aux), 32'd1);
      chk({tag, " proto_ready"}, rdy(v.aux), 32'd0);
      chk({tag, " proto_memvalid"}, 32'(bus.mem_valid), 32'd0);
      clear_req();
      tick();
      chk({tag, " proto_err_end"}, err(v.aux), 32'd0);
      chk({tag, " proto_owner_end"}, 32'(bus.owner), 32'd0);
      chk({tag, " proto_memvalid_end"}, 32'(bus.mem_valid), 32'd0);
    end else begin
      chk({tag, " owner"}, 32'(bus.owner), v.aux ? 32'd2 : 32'd1);
      chk({tag, " mem_valid"}, 32'(bus.mem_valid), 32'd1);
      chk({tag, " mem_addr"}, bus.mem_addr, v.addr);
      chk({tag, " mem_read"}, 32'(bus.mem_read), 32'(v.rd));
      chk({tag, " mem_write"}, 32'(bus.mem_write), 32'(v.wr));
      chk({tag, " mem_size"}, 32'(bus.mem_size), 32'(v.size));
      chk({tag, " mem_wdata"}, bus.mem_wdata, v.wdata);
      for (int w = 0; w < v.waits; w++) begin
        tick();
        chk({tag, " hold_valid"}, 32'(bus.mem_valid), 32'd1);
        chk({tag, " hold_wdata"}, bus.mem_wdata, v.wdata);
      end
      bus.mem_ready = 1;
      bus.mem_rdata = v.rdata;
      tick();
      bus.mem_ready = 0;
      bus.mem_rdata = '0;
      chk({tag, " ready"}, rdy(v.aux), 32'd1);
      chk({tag, " other_ready"}, rdy(!v.aux), 32'd0);
      chk({tag, " err"}, err(v.aux), 32'd0);
      chk({tag, " rdata"}, rdat(v.aux), v.rdata);
      chk({tag, " resp_memvalid"}, 32'(bus.mem_valid), 32'd0);
      clear_req();
      tick();
      chk({tag, " ready_end"}, rdy(v.aux), 32'd0);
      chk({tag, " rdata_hold"}, rdat(v.aux), v.rdata);
      chk({tag, " owner_end"}, 32'(bus.owner), 32'd0);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, bad;
    logic exp_aux;

    vecs[0] = '{1'b0, 32'h0000_0100, 32'h0,          1'b1, 1'b0, 4'h2, 1, 32'hDEAD_BEEF};
    vecs[1] = '{1'b1, 32'h0000_0080, 32'h1234_5678,  1'b0, 1'b1, 4'h0, 2, 32'hA5A5_A5A5};
    vecs[2] = '{1'b0, 32'h0000_0200, 32'hCAFE_F00D,  1'b0, 1'b1, 4'hF, 0, 32'h1111_1111};
    vecs[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0,          1'b1, 1'b0, 4'h3, 7, 32'h0BAD_F00D};
    vecs[4] = '{1'b0, 32'h0000_0400, 32'h0,          1'b1, 1'b0, 4'h1, 7, 32'h7777_0007};
    vecs[5] = '{1'b0, 32'h0000_0500, 32'h5555_5555,  1'b1, 1'b1, 4'h2, 0, 32'h0};
    vecs[6] = '{1'b1, 32'h0000_0600, 32'h0,          1'b0, 1'b0, 4'h2, 0, 32'h0};

    clear_req();
    bus.mem_ready = 0;
    bus.mem_rdata = '0;
    repeat (3) tick();
    chk("rst mem_valid", 32'(bus.mem_valid), 32'd0);
    chk("rst owner", 32'(bus.owner), 32'd0);
    chk("rst cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst cpu_err", 32'(bus.cpu_err), 32'd0);
    chk("rst aux_ready", 32'(bus.aux_ready), 32'd0);
    chk("rst aux_err", 32'(bus.aux_err), 32'd0);
    chk("rst cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst mem_addr", bus.mem_addr, 32'd0);
    reset = 1;

    // Contention straight out of reset: CPU first, then strict alternation.
    tick();
    bus.cpu_valid = 1; bus.cpu_addr = 32'h1000; bus.cpu_read = 1;
    bus.aux_valid = 1; bus.aux_addr = 32'h2000; bus.aux_read = 1;
    bus.mem_ready = 1;
    for (int k = 0; k < 4; k++) begin
      exp_aux = (k % 2) == 1;
      tick();
      chk("rr owner", 32'(bus.owner), exp_aux ? 32'd2 : 32'd1);
      chk("rr mem_addr", bus.mem_addr, exp_aux ? 32'h2000 : 32'h1000);
      bus.mem_rdata = 32'hA000_0000 + 32'(k);
      tick();
      chk("rr ready", rdy(exp_aux), 32'd1);
      chk("rr other_ready", rdy(!exp_aux), 32'd0);
      chk("rr rdata", rdat(exp_aux), 32'hA000_0000 + 32'(k));
      if (k == 3) clear_req();
      tick();
      chk("rr ready_end", rdy(exp_aux), 32'd0);
      chk("rr owner_idle", 32'(bus.owner), 32'd0);
    end
    bus.mem_ready = 0;
    tick();

    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Hung memory: exactly TIMEOUT cycles of mem_valid, then one err pulse.
    bus.cpu_valid = 1; bus.cpu_addr = 32'h0000_0700; bus.cpu_read = 1;
    bus.mem_ready = 0;
    tick();
    n = 0; bad = 0;
    while (bus.mem_valid === 1'b1 && n < 20) begin
      n++;
      if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0) bad++;
      tick();
    end
    chk("to xfer_cycles", 32'(n), 32'd8);
    chk("to early_pulse", 32'(bad), 32'd0);
    chk("to cpu_err", 32'(bus.cpu_err), 32'd1);
    chk("to cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("to aux_err", 32'(bus.aux_err), 32'd0);
    clear_req();
    tick();
    chk("to err_end", 32'(bus.cpu_err), 32'd0);
    chk("to owner_end", 32'(bus.owner), 32'd0);

    // Reset in the middle of a transfer.
    bus.cpu_valid = 1; bus.cpu_addr = 32'h0000_0300; bus.cpu_read = 1;
    tick();
    chk("mr mem_valid_pre", 32'(bus.mem_valid), 32'd1);
    tick();
    #2 reset = 0;
    #1;
    chk("mr mem_valid_async", 32'(bus.mem_valid), 32'd0);
    chk("mr owner_async", 32'(bus.owner), 32'd0);
    clear_req();
    bus.mem_ready = 1;
    tick();
    reset = 1;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (bus.cpu_ready !== 1'b0 || bus.cpu_err !== 1'b0 || bus.mem_valid !== 1'b0) bad++;
    end
    chk("mr no_pulse", 32'(bad), 32'd0);
    bus.mem_ready = 0;
    run_vec(vecs[0], "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
